mux_16_arbiter: RTL
===================

# mux_16_arbiter

Two-requester round-robin arbiter that shares one 16-bit output channel between sources A and B. It drives the `select` input of a `mux_16` datapath and registers the chosen word into a 1-deep output stage with valid/ready handshaking. A burst limit bounds how long one source holds the channel while the other waits. It sits in front of any shared 16-bit sink (register write port, memory bus) fed by two producers.

## Interface

- `WIDTH`, 16, data width; only 16 is supported, matching `mux_16`.
- `MAX_BURST`, 4, consecutive transfers allowed to one source before forced rotation; must be ≥1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `a_valid`  in  1  source A offers `a_data`.
- `a_data`  in  16  source A word.
- `a_ready`  out  1  A transfer accepted this cycle when `a_valid & a_ready`.
- `b_valid`  in  1  source B offers `b_data`.
- `b_data`  in  16  source B word.
- `b_ready`  out  1  B transfer accepted this cycle when `b_valid & b_ready`.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  16  registered output word.
- `out_ready`  in  1  sink consumes the word when `out_valid & out_ready`.
- `select`  out  1  current grant and mux select: 0 = A, 1 = B.

## Operation

- Grant FSM has two states: GRANT_A (`select`=0) and GRANT_B (`select`=1). A burst counter `cnt` runs from 0 to MAX_BURST-1.
- `load = !out_valid | out_ready`.
- `a_ready = load & !select & !rst`.
- `b_ready = load & select & !rst`.
- Both readies are combinational from registered state and `out_ready`.
- On a transfer from the granted source, the output register loads `mux_16(a_data, b_data, select)` and `out_valid` is set to 1.
- If `out_valid & out_ready` and no transfer occurs, `out_valid` clears and `out_data` holds its value.
- Grant update at each edge, in priority order:
  1. Transfer occurred and `cnt == MAX_BURST-1`: set `cnt` to 0. Flip `select` if the other source's valid is high; otherwise keep `select`.
  2. Transfer occurred: increment `cnt` and keep `select`.
  3. Granted source's valid is low and the other's valid is high: flip `select` and set `cnt` to 0.
  4. Otherwise: set `cnt` to 0 and keep `select`.
- A backpressure-stalled granted source (valid high, `load` low) keeps the grant, and `cnt` holds its value.
- Sources must hold valid and data stable until accepted. The arbiter never drops or duplicates a word.

## Timing

- Reset values: `out_valid`=0, `out_data`=16'h0000, `select`=0 (GRANT_A), `cnt`=0. While `rst` is high, `a_ready` and `b_ready` are 0.
- Reset mid-operation discards any word held in the output register.
- Latency: a word accepted in cycle N is visible on `out_data`/`out_valid` in cycle N+1.
- Throughput: one word per cycle while `out_ready` is held high.
- Rotation after burst expiry costs no bubble.
- Rotation because the granted source is idle costs exactly one bubble cycle.
- With both sources continuously valid and no backpressure, the output pattern is MAX_BURST words from A, then MAX_BURST from B, repeating.
- With MAX_BURST=1, A and B strictly alternate.

## Structure

- Package `arb_pkg` holds:
  - `typedef enum logic {GRANT_A=1'b0, GRANT_B=1'b1} grant_e`.
  - The `DATA_W=16` constant.
  - The default MAX_BURST constant.
- Instantiate the existing `mux_16` for data selection, with `select` driving its select input.
- Grant FSM, counter and output register live in this module; no further sub-modules.

## Test plan

- Apply reset, then release with both valids low. Required: `out_valid`=0, `select`=0, `a_ready`=1, `b_ready`=0.
- A only: present 16'h0101, 16'h0202, 16'h0303 back-to-back with `out_ready`=1. Required: those three words on `out_data` in cycles 1–3 after their acceptance, with `select` staying 0.
- A and B continuously valid, A=16'h5555, B=16'haaaa, MAX_BURST=4. Required output: 4×5555, 4×aaaa, 4×5555, with no bubbles.
- `out_ready`=0 for 3 cycles with A valid at 16'h1234. Required: `out_data` holds 16'h1234, `a_ready`=0 while stalled, and the next A word is accepted only after `out_ready` returns to 1.
- A idle, B valid at 16'hbeef. Required: one bubble cycle, then `select`=1, and 16'hbeef appears one cycle after acceptance.
- Assert `rst` while `out_valid`=1 and `select`=1. Required: on the next edge `out_valid`=0 and `select`=0, with both readies 0 during reset.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the two-source 16-bit round-robin arbiter.
package arb_pkg;

  localparam int unsigned DATA_W        = 16;
  localparam int unsigned MAX_BURST_DEF = 4;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/mux_16.sv
// 2:1 16-bit datapath mux; select 0 picks a, 1 picks b.
module mux_16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_select,
  output logic [15:0] o_y
);

  assign o_y = i_select ? i_b : i_a;

endmodule

// File: rtl/mux_16_arbiter.sv
// Round-robin arbiter sharing one 16-bit channel between sources A and B,
// with a burst limit and a 1-deep registered valid/ready output stage.
module mux_16_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH     = DATA_W,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             select
);

  localparam int unsigned     CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  grant_e             r_state;
  grant_e             w_state_nxt;
  grant_e             w_flip;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic               w_load;
  logic               w_xfer;
  logic               w_gnt_valid;
  logic               w_oth_valid;
  logic [DATA_W-1:0]  w_mux;

  // Output stage can take a word when empty or draining this cycle.
  assign w_load  = ~r_out_valid | out_ready;
  assign a_ready = w_load & (r_state == GRANT_A) & ~rst;
  assign b_ready = w_load & (r_state == GRANT_B) & ~rst;
  assign w_xfer  = (a_valid & a_ready) | (b_valid & b_ready);

  assign w_gnt_valid = (r_state == GRANT_A) ? a_valid : b_valid;
  assign w_oth_valid = (r_state == GRANT_A) ? b_valid : a_valid;
  assign w_flip      = (r_state == GRANT_A) ? GRANT_B : GRANT_A;

  assign select    = r_state;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  mux_16 u_mux (
    .i_a      (a_data),
    .i_b      (b_data),
    .i_select (select),
    .o_y      (w_mux)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= GRANT_A;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Grant update; a stalled granted source keeps both grant and burst count.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    if (w_xfer) begin
      if (r_cnt == CNT_LAST) begin
        if (w_oth_valid) w_state_nxt = w_flip;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else if (!w_gnt_valid && w_oth_valid) begin
      w_state_nxt = w_flip;
    end else if (w_gnt_valid && !w_load) begin
      w_cnt_nxt = r_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule
